// File: rtl/c2c_mem_slave_pkg.sv
// Shared constants and types for the c2c memory responder.
// Holds the lane-select shorthands, FSM states and access opcodes.
package c2c_pkg;

   localparam logic [3:0] SEL_BYTE = 4'b0001;
   localparam logic [3:0] SEL_HALF = 4'b0011;
   localparam logic [3:0] SEL_WORD = 4'b1111;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

   typedef enum logic {OP_READ, OP_WRITE} op_e;

endpackage

// File: rtl/c2c_mem_slave_if.sv
// c2c read and write channel interfaces used between the LSU and its data memory.
// The master drives the request fields; the slave answers with ack (and read data).
interface c2c_r #(parameter int XLEN = 32) ();
   logic [XLEN-1:0] addr;
   logic [3:0]      sel;
   logic            re;
   logic [XLEN-1:0] data;
   logic            ack;

   modport master (output addr, sel, re, input data, ack);
   modport slave  (input addr, sel, re, output data, ack);
endinterface

interface c2c_w #(parameter int XLEN = 32) ();
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] data;
   logic [3:0]      sel;
   logic            we;
   logic            ack;

   modport master (output addr, data, sel, we, input ack);
   modport slave  (input addr, data, sel, we, output ack);
endinterface

// File: rtl/c2c_mem_slave_lane_align.sv
// Combinational lane aligner for a right-justified 32-bit bus.
// Moves bus lanes to word byte offsets for writes and back down for reads.
module c2c_lane_align (
   input  logic [1:0]  offset_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        ovf_o
);

   logic [7:0]  selWide;
   logic [4:0]  bitShift;
   logic [31:0] laneMask;
   logic [31:0] rShifted;

   // Lanes shifted past byte 3 land in the upper nibble and flag an overflow.
   assign selWide  = {4'b0000, sel_i} << offset_i;
   assign bitShift = {offset_i, 3'b000};
   assign be_o     = selWide[3:0];
   assign ovf_o    = |selWide[7:4];

   assign wdata_o  = wdata_i << bitShift;
   assign rShifted = rword_i >> bitShift;
   assign laneMask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
   assign rdata_o  = rShifted & laneMask;

endmodule

// File: rtl/c2c_mem_slave.sv
// c2c responder: word-organised data RAM with byte lanes, LATENCY wait states and a one-cycle ack.
// Optional misalignment trap enabled by defining C2C_MEM_MISALIGN_TRAP_EN.
module c2c_mem_slave
   import c2c_pkg::*;
#(
   parameter int    XLEN        = 32,
   parameter int    DEPTH_WORDS = 1024,
   parameter int    LATENCY     = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic clk,
   input  logic reset,
   c2c_r.slave  data_bus_r,
   c2c_w.slave  data_bus_w
`ifdef C2C_MEM_MISALIGN_TRAP_EN
   ,
   output logic misalign_err
`endif
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int AW    = IDX_W + 2;

`ifdef C2C_MEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   state_e          state_q, state_d;
   op_e             op_q, op_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [3:0]      sel_q, sel_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [31:0]     rdata_q;
   logic            rack_q, wack_q;

   logic [IDX_W-1:0] idx;
   logic             enterAck;
   logic             block;
   logic [3:0]       be;
   logic [31:0]      wdataSh;
   logic [31:0]      rdataAl;
   logic [31:0]      rword;
   logic             ovf;

   // The _d access fields describe the access on the ACK-entry edge, which with
   // LATENCY=0 is the acceptance edge itself, so RAM effects key off them.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      sel_d   = sel_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (data_bus_w.we) begin
               op_d    = OP_WRITE;
               addr_d  = data_bus_w.addr[AW-1:0];
               sel_d   = data_bus_w.sel;
               wdata_d = data_bus_w.data;
               cnt_d   = 4'(LATENCY);
               state_d = (LATENCY > 0) ? WAIT : ACK;
            end else if (data_bus_r.re) begin
               op_d    = OP_READ;
               addr_d  = data_bus_r.addr[AW-1:0];
               sel_d   = data_bus_r.sel;
               cnt_d   = 4'(LATENCY);
               state_d = (LATENCY > 0) ? WAIT : ACK;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = ACK;
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign idx      = addr_d[AW-1:2];
   assign rword    = mem[idx];
   assign enterAck = (state_d == ACK);
   assign block    = TRAP_EN & ovf;

   c2c_lane_align u_align (
      .offset_i (addr_d[1:0]),
      .sel_i    (sel_d),
      .wdata_i  (wdata_d),
      .rword_i  (rword),
      .be_o     (be),
      .wdata_o  (wdataSh),
      .rdata_o  (rdataAl),
      .ovf_o    (ovf)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= OP_READ;
         addr_q  <= '0;
         sel_q   <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         rack_q  <= 1'b0;
         wack_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rack_q  <= enterAck && (op_d == OP_READ);
         wack_q  <= enterAck && (op_d == OP_WRITE);
         rdata_q <= (enterAck && (op_d == OP_READ) && !block) ? rdataAl : '0;
      end
   end

   // RAM contents survive reset; a reset edge suppresses any commit.
   always_ff @(posedge clk) begin
      if (!reset && enterAck && (op_d == OP_WRITE) && !block) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) mem[idx][8*k +: 8] <= wdataSh[8*k +: 8];
         end
      end
   end

`ifdef C2C_MEM_MISALIGN_TRAP_EN
   logic misalign_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         misalign_q <= 1'b0;
      end else if (enterAck && ovf) begin
         misalign_q <= 1'b1;
      end
   end

   assign misalign_err = misalign_q;
`endif

   assign data_bus_r.data = rdata_q;
   assign data_bus_r.ack  = rack_q;
   assign data_bus_w.ack  = wack_q;

endmodule

// File: tb/tb_c2c_mem_slave.sv
// Directed self-checking bench for c2c_mem_slave (LATENCY=1 main instance, LATENCY=3 instance for reset-in-WAIT).
// Expected values are hand-computed; trap-build expectations switch on C2C_MEM_MISALIGN_TRAP_EN.
module tb_c2c_mem_slave;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   c2c_r rIf  ();
   c2c_w wIf  ();
   c2c_r rIf3 ();
   c2c_w wIf3 ();

`ifdef C2C_MEM_MISALIGN_TRAP_EN
   logic misErr, misErr3;
   localparam logic [31:0] W100_AFTER_HALF = 32'hDEADA5EF;
`else
   localparam logic [31:0] W100_AFTER_HALF = 32'h34ADA5EF;
`endif

   c2c_mem_slave #(.LATENCY(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_bus_r (rIf),
      .data_bus_w (wIf)
`ifdef C2C_MEM_MISALIGN_TRAP_EN
      , .misalign_err (misErr)
`endif
   );

   c2c_mem_slave #(.LATENCY(3)) dutSlow (
      .clk        (clk),
      .reset      (reset),
      .data_bus_r (rIf3),
      .data_bus_w (wIf3)
`ifdef C2C_MEM_MISALIGN_TRAP_EN
      , .misalign_err (misErr3)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Master-side write: lat is the number of falling edges until ack (-1 on timeout).
   task automatic busWrite(input bit slow, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int lat);
      if (slow) begin
         wIf3.addr = a; wIf3.data = d; wIf3.sel = s; wIf3.we = 1'b1;
      end else begin
         wIf.addr = a; wIf.data = d; wIf.sel = s; wIf.we = 1'b1;
      end
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if ((slow ? wIf3.ack : wIf.ack) === 1'b1) begin
            lat = i;
            break;
         end
      end
      wIf.we = 1'b0; wIf3.we = 1'b0;
      @(negedge clk);
   endtask

   task automatic busRead(input bit slow, input logic [31:0] a, input logic [3:0] s,
                          output int lat, output logic [31:0] d, output logic [31:0] dAfter);
      if (slow) begin
         rIf3.addr = a; rIf3.sel = s; rIf3.re = 1'b1;
      end else begin
         rIf.addr = a; rIf.sel = s; rIf.re = 1'b1;
      end
      lat = -1;
      d   = 'x;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if ((slow ? rIf3.ack : rIf.ack) === 1'b1) begin
            lat = i;
            d   = slow ? rIf3.data : rIf.data;
            break;
         end
      end
      rIf.re = 1'b0; rIf3.re = 1'b0;
      @(negedge clk);
      dAfter = slow ? rIf3.data : rIf.data;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rIf.addr = '0; rIf.sel = '0; rIf.re = 1'b0;
      wIf.addr = '0; wIf.data = '0; wIf.sel = '0; wIf.we = 1'b0;
      rIf3.addr = '0; rIf3.sel = '0; rIf3.re = 1'b0;
      wIf3.addr = '0; wIf3.data = '0; wIf3.sel = '0; wIf3.we = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({rIf.ack, wIf.ack, rIf3.ack, wIf3.ack} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_acks: got %b expected 0000", {rIf.ack, wIf.ack, rIf3.ack, wIf3.ack});
      end
      checks++;
      if (rIf.data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_rdata: got %h expected 00000000", rIf.data);
      end
`ifdef C2C_MEM_MISALIGN_TRAP_EN
      checks++;
      if (misErr !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_misalign: got %b expected 0", misErr);
      end
`endif
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_word();
      int lat;
      logic [31:0] d, dAfter;
      busWrite(0, 32'h100, 32'hDEADBEEF, c2c_pkg::SEL_WORD, lat);
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("[TB] FAIL word_write_latency: got %0d expected 2", lat);
      end
      busRead(0, 32'h100, c2c_pkg::SEL_WORD, lat, d, dAfter);
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("[TB] FAIL word_read_latency: got %0d expected 2", lat);
      end
      checks++;
      if (d !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL word_read_data: got %h expected DEADBEEF", d);
      end
      checks++;
      if (dAfter !== 32'h0) begin
         errors++;
         $display("[TB] FAIL rdata_after_ack: got %h expected 00000000", dAfter);
      end
   endtask

   task automatic test_byte();
      int lat;
      logic [31:0] d, dAfter;
      busWrite(0, 32'h101, 32'h000000A5, c2c_pkg::SEL_BYTE, lat);
      busRead(0, 32'h100, c2c_pkg::SEL_WORD, lat, d, dAfter);
      checks++;
      if (d !== 32'hDEADA5EF) begin
         errors++;
         $display("[TB] FAIL byte_write_word: got %h expected DEADA5EF", d);
      end
      busRead(0, 32'h103, c2c_pkg::SEL_BYTE, lat, d, dAfter);
      checks++;
      if (d !== 32'h000000DE) begin
         errors++;
         $display("[TB] FAIL byte_read_0x103: got %h expected 000000DE", d);
      end
   endtask

   task automatic test_half_cross();
      int lat;
      logic [31:0] d, dAfter;
      busWrite(0, 32'h104, 32'h55667788, c2c_pkg::SEL_WORD, lat);
      busWrite(0, 32'h103, 32'h00001234, c2c_pkg::SEL_HALF, lat);
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("[TB] FAIL half_cross_ack: got %0d expected 2", lat);
      end
      busRead(0, 32'h100, c2c_pkg::SEL_WORD, lat, d, dAfter);
      checks++;
      if (d !== W100_AFTER_HALF) begin
         errors++;
         $display("[TB] FAIL half_cross_word: got %h expected %h", d, W100_AFTER_HALF);
      end
      busRead(0, 32'h104, c2c_pkg::SEL_WORD, lat, d, dAfter);
      checks++;
      if (d !== 32'h55667788) begin
         errors++;
         $display("[TB] FAIL half_cross_next_word: got %h expected 55667788", d);
      end
`ifdef C2C_MEM_MISALIGN_TRAP_EN
      checks++;
      if (misErr !== 1'b1) begin
         errors++;
         $display("[TB] FAIL misalign_flag: got %b expected 1", misErr);
      end
`endif
   endtask

   task automatic test_sel_zero();
      int lat;
      logic [31:0] d, dAfter;
      busWrite(0, 32'h100, 32'hFFFFFFFF, 4'b0000, lat);
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("[TB] FAIL sel0_write_ack: got %0d expected 2", lat);
      end
      busRead(0, 32'h100, 4'b0000, lat, d, dAfter);
      checks++;
      if (lat !== 2 || d !== 32'h0) begin
         errors++;
         $display("[TB] FAIL sel0_read: got lat %0d data %h expected lat 2 data 00000000", lat, d);
      end
      busRead(0, 32'h100, c2c_pkg::SEL_WORD, lat, d, dAfter);
      checks++;
      if (d !== W100_AFTER_HALF) begin
         errors++;
         $display("[TB] FAIL sel0_no_effect: got %h expected %h", d, W100_AFTER_HALF);
      end
   endtask

   task automatic test_back_to_back();
      int wLat, rLat;
      logic rAckEarly;
      logic [31:0] d;
      wIf.addr = 32'h200; wIf.data = 32'hCAFEF00D; wIf.sel = c2c_pkg::SEL_WORD; wIf.we = 1'b1;
      rIf.addr = 32'h200; rIf.sel = c2c_pkg::SEL_WORD; rIf.re = 1'b1;
      wLat = -1;
      rAckEarly = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (rIf.ack === 1'b1) rAckEarly = 1'b1;
         if (wIf.ack === 1'b1) begin
            wLat = i;
            break;
         end
      end
      wIf.we = 1'b0;
      rLat = -1;
      d = 'x;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (rIf.ack === 1'b1) begin
            rLat = i;
            d = rIf.data;
            break;
         end
      end
      rIf.re = 1'b0;
      @(negedge clk);
      checks++;
      if (wLat !== 2 || rAckEarly !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_write_first: got wlat %0d rack %b expected wlat 2 rack 0", wLat, rAckEarly);
      end
      checks++;
      if (rLat !== 3) begin
         errors++;
         $display("[TB] FAIL b2b_read_spacing: got %0d expected 3", rLat);
      end
      checks++;
      if (d !== 32'hCAFEF00D) begin
         errors++;
         $display("[TB] FAIL b2b_read_data: got %h expected CAFEF00D", d);
      end
   endtask

   task automatic test_alias();
      int lat;
      logic [31:0] d, dAfter;
      busWrite(0, 32'h00001004, 32'h11223344, c2c_pkg::SEL_WORD, lat);
      busRead(0, 32'h00000004, c2c_pkg::SEL_WORD, lat, d, dAfter);
      checks++;
      if (d !== 32'h11223344) begin
         errors++;
         $display("[TB] FAIL alias_read: got %h expected 11223344", d);
      end
`ifdef C2C_MEM_MISALIGN_TRAP_EN
      checks++;
      if (misErr !== 1'b1) begin
         errors++;
         $display("[TB] FAIL misalign_sticky: got %b expected 1", misErr);
      end
`endif
   endtask

   task automatic test_reset_wait();
      int lat;
      logic ackSeen;
      logic [31:0] d, dAfter;
      busWrite(1, 32'h300, 32'h0BADF00D, c2c_pkg::SEL_WORD, lat);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("[TB] FAIL slow_write_latency: got %0d expected 4", lat);
      end
      wIf3.addr = 32'h300; wIf3.data = 32'hFFFFFFFF; wIf3.sel = c2c_pkg::SEL_WORD; wIf3.we = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      wIf3.we = 1'b0;
      @(negedge clk);
      ackSeen = wIf3.ack;
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         ackSeen = ackSeen | wIf3.ack;
      end
      checks++;
      if (ackSeen !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_wait_no_ack: got %b expected 0", ackSeen);
      end
      busRead(1, 32'h300, c2c_pkg::SEL_WORD, lat, d, dAfter);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("[TB] FAIL reset_wait_idle: got read latency %0d expected 4", lat);
      end
      checks++;
      if (d !== 32'h0BADF00D) begin
         errors++;
         $display("[TB] FAIL reset_wait_ram: got %h expected 0BADF00D", d);
      end
`ifdef C2C_MEM_MISALIGN_TRAP_EN
      checks++;
      if (misErr !== 1'b0) begin
         errors++;
         $display("[TB] FAIL misalign_reset_clear: got %b expected 0", misErr);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half_cross();
      test_sel_zero();
      test_back_to_back();
      test_alias();
      test_reset_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
